// File: rtl/execution_stage_mdu.sv
// MIPS execute stage registered into the EX/MEM boundary, with an iterative
// unsigned multiply/divide unit (one bit per cycle) and HI/LO registers.
module execution_stage_mdu #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall_in,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_extended,
  input  logic [REG_AW-1:0] inst_20_16,
  input  logic [REG_AW-1:0] inst_15_11,
  output logic              busy,
  output logic              ex_valid,
  output logic [DATA_W-1:0] add_result,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] read_data2_out,
  output logic [REG_AW-1:0] dest_reg,
  output logic              zero_out,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic [0:0]          r_state;
  logic [CW-1:0]       r_count;
  logic                r_div;
  logic [DATA_W-1:0]   r_opb;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_ex_valid;
  logic [DATA_W-1:0]   r_add;
  logic [DATA_W-1:0]   r_alu;
  logic [DATA_W-1:0]   r_rd2;
  logic [REG_AW-1:0]   r_dest;
  logic                r_zero;

  logic [DATA_W-1:0]   w_b;
  logic [5:0]          w_funct;
  logic                w_is_mdu;
  logic                w_is_div;
  logic [DATA_W-1:0]   w_alu;
  logic [REG_AW-1:0]   w_dest;
  logic [DATA_W-1:0]   w_branch;

  assign w_b      = ALUSrc ? sign_extended : read_data2;
  assign w_funct  = sign_extended[5:0];
  assign w_is_mdu = (ALUOp == 2'b10) && ((w_funct == F_MULTU) || (w_funct == F_DIVU));
  assign w_is_div = (w_funct == F_DIVU);
  assign w_dest   = RegDst ? inst_15_11 : inst_20_16;
  assign w_branch = pc_plus4 + (sign_extended << 2);

  always_comb begin
    w_alu = '0;
    case (ALUOp)
      2'b00: w_alu = read_data1 + w_b;
      2'b01: w_alu = read_data1 - w_b;
      2'b11: w_alu = read_data1 | w_b;
      default: begin
        case (w_funct)
          F_ADD:   w_alu = read_data1 + w_b;
          F_SUB:   w_alu = read_data1 - w_b;
          F_AND:   w_alu = read_data1 & w_b;
          F_OR:    w_alu = read_data1 | w_b;
          F_SLT:   w_alu = ($signed(read_data1) < $signed(w_b)) ? DATA_W'(1) : '0;
          F_MFHI:  w_alu = r_hi;
          F_MFLO:  w_alu = r_lo;
          default: w_alu = '0;
        endcase
      end
    endcase
  end

  // Shift-add multiply: r_acc = {partial product, remaining multiplier bits}.
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_prod_next;

  assign w_mul_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opb};
  assign w_prod_next = r_acc[0] ? {w_mul_sum, r_acc[DATA_W-1:1]}
                                : {1'b0, r_acc[2*DATA_W-1:1]};

  // Restoring divide: r_acc = {remainder, dividend bits shifting into quotient}.
  logic [DATA_W:0]     w_shift;
  logic                w_ge;
  logic [DATA_W-1:0]   w_sub;
  logic [DATA_W-1:0]   w_rem_next;
  logic [DATA_W-1:0]   w_quo_next;
  logic [2*DATA_W-1:0] w_acc_next;

  assign w_shift    = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_ge       = w_shift >= {1'b0, r_opb};
  assign w_sub      = w_shift[DATA_W-1:0] - r_opb;
  assign w_rem_next = w_ge ? w_sub : w_shift[DATA_W-1:0];
  assign w_quo_next = {r_acc[DATA_W-2:0], w_ge};
  assign w_acc_next = r_div ? {w_rem_next, w_quo_next} : w_prod_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_div      <= 1'b0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_ex_valid <= 1'b0;
      r_add      <= '0;
      r_alu      <= '0;
      r_rd2      <= '0;
      r_dest     <= '0;
      r_zero     <= 1'b0;
    end else if (!stall_in) begin
      if (r_state == S_IDLE) begin
        if (in_valid) begin
          r_add  <= w_branch;
          r_rd2  <= read_data2;
          r_dest <= w_dest;
          if (w_is_mdu) begin
            r_state    <= S_RUN;
            r_count    <= CW'(DATA_W);
            r_acc      <= {{DATA_W{1'b0}}, read_data1};
            r_opb      <= w_b;
            r_div      <= w_is_div;
            r_ex_valid <= 1'b0;
          end else begin
            r_alu      <= w_alu;
            r_zero     <= (w_alu == '0);
            r_ex_valid <= 1'b1;
          end
        end else begin
          r_ex_valid <= 1'b0;
        end
      end else begin
        r_acc   <= w_acc_next;
        r_count <= r_count - CW'(1);
        // Final iteration: commit HI/LO and retire the result into EX/MEM.
        if (r_count == CW'(1)) begin
          r_hi       <= w_acc_next[2*DATA_W-1:DATA_W];
          r_lo       <= w_acc_next[DATA_W-1:0];
          r_alu      <= w_acc_next[DATA_W-1:0];
          r_zero     <= (w_acc_next[DATA_W-1:0] == '0);
          r_ex_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
      end
    end
  end

  assign busy           = (r_state == S_RUN);
  assign ex_valid       = r_ex_valid;
  assign add_result     = r_add;
  assign alu_result     = r_alu;
  assign read_data2_out = r_rd2;
  assign dest_reg       = r_dest;
  assign zero_out       = r_zero;
  assign hi             = r_hi;
  assign lo             = r_lo;

endmodule
